// File: rtl/logicnets_pkg.sv
// Shared types and constants for the generated LUT-network layer plumbing.
package logicnets_pkg;

  // Default width of the throughput debug counters.
  localparam int LN_CNT_WIDTH = 32;

  // Occupancy state of a layer boundary stage; the encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/layer_skid_reg_if.sv
// Valid/ready handshake bundle between two layers of the LUT network.
// slave: the boundary stage's view; master: the view of whatever drives the
// upstream side and consumes the downstream side.
interface layer_skid_reg_if #(
  parameter int DataWidth = 256
);

  logic                 s_valid;
  logic                 s_ready;
  logic [DataWidth-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DataWidth-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/ln_sat_counter.sv
// Event counter for throughput debug: either wraps modulo 2^Width or
// saturates at all-ones, selected by Wrap.
module ln_sat_counter #(
  parameter int Width = 32,
  parameter bit Wrap  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  localparam logic [Width-1:0] CntZero = {Width{1'b0}};
  localparam logic [Width-1:0] CntOne  = {{(Width-1){1'b0}}, 1'b1};
  localparam logic [Width-1:0] CntMax  = {Width{1'b1}};

  logic [Width-1:0] cnt_r;

  // Count one per asserted inc; in saturating mode stop at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CntZero;
    end else if (inc && (Wrap || (cnt_r != CntMax))) begin
      cnt_r <= cnt_r + CntOne;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/layer_skid_reg.sv
// Registered layer boundary with a 2-entry skid buffer. s_ready is derived
// from registered state only, so no combinational path runs from the next
// layer's m_ready back to the previous layer, yet full throughput is kept.
module layer_skid_reg
  import logicnets_pkg::*;
#(
  parameter int DataWidth = 256,
  parameter int CntWidth  = LN_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  layer_skid_reg_if.slave     bus,
  output logic [1:0]          occ,
  output logic [CntWidth-1:0] xfer_cnt,
  output logic [CntWidth-1:0] stall_cnt
);

  localparam logic [DataWidth-1:0] DataZero = {DataWidth{1'b0}};

  skid_state_t          state_r;
  logic [DataWidth-1:0] main_r;
  logic [DataWidth-1:0] skid_r;

  logic m_valid_s;
  logic s_ready_s;
  logic s_fire_s;
  logic m_fire_s;
  logic stall_ev_s;

  assign m_valid_s  = (state_r != EMPTY);
  assign s_ready_s  = !rst && (state_r != FULL);
  assign s_fire_s   = bus.s_valid && s_ready_s;
  assign m_fire_s   = m_valid_s && bus.m_ready;
  assign stall_ev_s = m_valid_s && !bus.m_ready;

  // Occupancy FSM and datapath: main_r always holds the oldest vector, the
  // skid entry only fills when a vector arrives while the head is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
      main_r  <= DataZero;
      skid_r  <= DataZero;
    end else begin
      case (state_r)
        EMPTY: begin
          if (s_fire_s) begin
            main_r  <= bus.s_data;
            state_r <= ONE;
          end else begin
            state_r <= EMPTY;
          end
        end
        ONE: begin
          if (s_fire_s && m_fire_s) begin
            main_r  <= bus.s_data;
            state_r <= ONE;
          end else if (s_fire_s) begin
            skid_r  <= bus.s_data;
            state_r <= FULL;
          end else if (m_fire_s) begin
            state_r <= EMPTY;
          end else begin
            state_r <= ONE;
          end
        end
        FULL: begin
          if (m_fire_s) begin
            main_r  <= skid_r;
            state_r <= ONE;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = m_valid_s;
  assign bus.m_data  = main_r;
  assign occ         = state_r;

  ln_sat_counter #(
    .Width (CntWidth),
    .Wrap  (1'b1)
  ) u_xfer_cnt (
    .clk (clk),
    .rst (rst),
    .inc (m_fire_s),
    .cnt (xfer_cnt)
  );

  ln_sat_counter #(
    .Width (CntWidth),
    .Wrap  (1'b0)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_ev_s),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_layer_skid_reg.sv
// Scoreboard bench for layer_skid_reg: accepted vectors are queued by the
// stimulus side, a monitor pops them on every output transfer and tracks a
// FIFO-occupancy / counter model. A second, narrow-counter instance covers
// stall saturation and transfer wrap.
`timescale 1ns/1ps
module tb_layer_skid_reg;

  localparam int DW  = 16;
  localparam int DW2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst2;
  logic [1:0]  occ;
  logic [1:0]  occ2;
  logic [31:0] xfer_cnt;
  logic [31:0] stall_cnt;
  logic [3:0]  xfer2;
  logic [3:0]  stall2;

  layer_skid_reg_if #(.DataWidth(DW))  bus ();
  layer_skid_reg_if #(.DataWidth(DW2)) bus2 ();

  layer_skid_reg #(.DataWidth(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .occ       (occ),
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
  );

  layer_skid_reg #(.DataWidth(DW2), .CntWidth(4)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .bus       (bus2),
    .occ       (occ2),
    .xfer_cnt  (xfer2),
    .stall_cnt (stall2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: vectors in flight, occupancy and event counters.
  logic [DW-1:0] exp_q[$];
  int            m_occ   = 0;
  logic [31:0]   m_xfer  = 32'd0;
  longint        m_stall = 0;
  bit            mon_en  = 1'b0;

  // Stimulus side: record each accepted vector in arrival order.
  always @(negedge clk) begin
    if (!rst && bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
  end

  // Monitor: compare outputs to the model, then advance the model by one cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("occ",       {62'd0, occ},       m_occ);
      chk("s_ready",   {63'd0, bus.s_ready}, {63'd0, (!rst && m_occ < 2)});
      chk("m_valid",   {63'd0, bus.m_valid}, {63'd0, (m_occ > 0)});
      chk("xfer_cnt",  {32'd0, xfer_cnt},  {32'd0, m_xfer});
      chk("stall_cnt", {32'd0, stall_cnt}, m_stall);
      if (rst) begin
        m_occ   = 0;
        m_xfer  = 32'd0;
        m_stall = 0;
        exp_q.delete();
      end else begin
        bit sf;
        bit mf;
        sf = bus.s_valid && (m_occ < 2);
        mf = (m_occ > 0) && bus.m_ready;
        if (mf) begin
          if (exp_q.size() == 0) chk("underflow", 64'd1, 64'd0);
          else chk("m_data", {48'd0, bus.m_data}, {48'd0, exp_q.pop_front()});
          m_xfer = m_xfer + 32'd1;
        end
        if ((m_occ > 0) && !bus.m_ready && (m_stall < 64'hFFFF_FFFF)) m_stall++;
        m_occ = m_occ + (sf ? 1 : 0) - (mf ? 1 : 0);
      end
    end
  end

  // Offer one vector and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    @(negedge clk);
    while (!bus.s_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  bit done = 1'b0;

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.m_ready = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst2 = 1'b0;

    // Idle after reset.
    repeat (5) @(negedge clk);
    chk("idle_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("idle_s_ready", {63'd0, bus.s_ready}, 64'd1);
    chk("idle_occ",     {62'd0, occ},         64'd0);
    chk("idle_xfer",    {32'd0, xfer_cnt},    64'd0);
    chk("idle_stall",   {32'd0, stall_cnt},   64'd0);
    @(posedge clk);
    #1;

    // Full-rate stream of 16 vectors.
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(i[DW-1:0]);
    repeat (3) @(negedge clk);
    chk("stream_xfer",  {32'd0, xfer_cnt},  64'd16);
    chk("stream_stall", {32'd0, stall_cnt}, 64'd0);
    chk("stream_drain", exp_q.size(),       64'd0);
    @(posedge clk);
    #1;

    // Backpressure: two absorbed, third held upstream.
    bus.m_ready = 1'b0;
    send(16'h00A1);
    send(16'h00A2);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h00A3;
    @(negedge clk);
    chk("bp_occ",     {62'd0, occ},         64'd2);
    chk("bp_s_ready", {63'd0, bus.s_ready}, 64'd0);
    chk("bp_head",    {48'd0, bus.m_data},  64'hA1);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    send(16'h00A3);
    repeat (4) @(negedge clk);
    chk("bp_drain", exp_q.size(), 64'd0);
    @(posedge clk);
    #1;

    // Random valid/ready, 10k vectors.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(1, 0) == 1) begin
            @(posedge clk);
            #1;
          end
          send(DW'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.m_ready = ($urandom_range(1, 0) == 1);
          @(posedge clk);
          #1;
        end
      end
    join
    bus.m_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rand_drain", exp_q.size(), 64'd0);
    @(posedge clk);
    #1;

    // Reset while FULL discards both buffered vectors.
    bus.m_ready = 1'b0;
    send(16'hBEE1);
    send(16'hBEE2);
    @(negedge clk);
    chk("rst_pre_occ", {62'd0, occ}, 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_occ",     {62'd0, occ},         64'd0);
    chk("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("rst_xfer",    {32'd0, xfer_cnt},    64'd0);
    chk("rst_stall",   {32'd0, stall_cnt},   64'd0);
    chk("rst_m_data",  {48'd0, bus.m_data},  64'd0);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    send(16'h0C01);
    send(16'h0C02);
    repeat (4) @(negedge clk);
    chk("rst_after_xfer", {32'd0, xfer_cnt}, 64'd2);
    chk("rst_after_drain", exp_q.size(), 64'd0);

    // Narrow counters: stall saturation and transfer wrap.
    @(posedge clk);
    #1;
    bus2.m_ready = 1'b0;
    bus2.s_valid = 1'b1;
    bus2.s_data  = 8'h55;
    @(posedge clk);
    #1;
    bus2.s_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_10", {60'd0, stall2}, 64'd10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_max", {60'd0, stall2}, 64'hF);
    chk("sat_head",      {56'd0, bus2.m_data}, 64'h55);
    @(posedge clk);
    #1;
    bus2.m_ready = 1'b1;
    bus2.s_valid = 1'b1;
    bus2.s_data  = 8'h01;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      bus2.s_data = bus2.s_data + 8'h01;
    end
    bus2.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_xfer",  {60'd0, xfer2},  64'd1);
    chk("wrap_occ",   {62'd0, occ2},   64'd0);
    chk("wrap_stall", {60'd0, stall2}, 64'hF);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_skid_reg.md
# layer_skid_reg

Registered layer-boundary stage for the generated LUT networks. It sits between the outputs of one layer (for example the concatenated 1-bit neuron outputs of `ens0_layer0`) and the inputs of the next layer's LUT neurons. It replaces the bare pipeline register with a valid/ready handshake and a 2-entry skid buffer, so backpressure from downstream never drops a vector and full throughput is kept. It also provides transfer and stall counters for throughput debug.

## Interface
- `DataWidth`, default 256: width of the layer activation vector carried per transfer.
- `CntWidth`, default 32: width of both debug counters.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  upstream vector valid.
- `s_ready`  out  1  stage can accept; transfer occurs when `s_valid && s_ready`.
- `s_data`  in  DataWidth  upstream layer outputs.
- `m_valid`  out  1  vector available to the next layer.
- `m_ready`  in  1  next layer consumes; transfer occurs when `m_valid && m_ready`.
- `m_data`  out  DataWidth  registered vector feeding the next layer's neuron inputs.
- `occ`  out  2  entries held: 0, 1 or 2.
- `xfer_cnt`  out  CntWidth  count of completed output transfers.
- `stall_cnt`  out  CntWidth  count of cycles with `m_valid && !m_ready`.

## Operation
- Storage:
  - main register `main_q`, which drives `m_data`;
  - skid register `skid_q`.
- State machine (`occ` mirrors it):
  - EMPTY (0);
  - ONE (1): main valid;
  - FULL (2): main and skid valid.
- Outputs:
  - `m_valid` = state != EMPTY.
  - `s_ready` = !rst && state != FULL. It depends only on registered state, with no combinational path from `m_ready`.
- Definitions: s_fire = `s_valid && s_ready`; m_fire = `m_valid && m_ready`.
- Transitions:
  - EMPTY: s_fire → main_q ← s_data, go to ONE. Otherwise stay.
  - ONE, s_fire and m_fire together → main_q ← s_data, stay in ONE.
  - ONE, s_fire only → skid_q ← s_data, go to FULL.
  - ONE, m_fire only → go to EMPTY.
  - ONE, neither → hold.
  - FULL: s_ready is 0. m_fire → main_q ← skid_q, go to ONE. Otherwise hold.
- Ordering: strict FIFO; vectors leave in arrival order and none are duplicated or dropped.
- `m_data` while `m_valid` = 0 keeps its last value. Downstream must not rely on it.
- `xfer_cnt`: increments on every m_fire and wraps modulo 2^CntWidth.
- `stall_cnt`: increments on every cycle with `m_valid && !m_ready`, saturating at all-ones.
- Reset, including mid-transfer: the next state is EMPTY, `main_q`, `skid_q` and both counters are 0, and any in-flight vector is discarded. Inputs are ignored in any cycle where `rst` = 1.

## Timing
- Reset values: `m_valid` 0, `m_data` 0, `occ` 0, `xfer_cnt` 0, `stall_cnt` 0. `s_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Latency: 1 cycle. A vector accepted on edge N is presented with `m_valid` = 1 after edge N.
- Throughput: 1 vector per cycle when `m_ready` is held high.
- After FULL is entered, `s_ready` drops in the very next cycle, so at most one vector is absorbed per stall onset.
- Leaving FULL: `s_ready` returns to 1 in the cycle after the m_fire that drained the skid entry.
- Counters update on the same edge as the event they record.

## Structure
- Shared package `logicnets_pkg`:
  - enum `skid_state_t` {EMPTY, ONE, FULL};
  - constant `LN_CNT_WIDTH` = 32.
- One sub-module, `ln_sat_counter` (parameters Width, Wrap), used twice:
  - Wrap=1 for `xfer_cnt`;
  - Wrap=0 for `stall_cnt`.
- Datapath and FSM live in `layer_skid_reg`, instantiated once per layer boundary by the network generator.

## Test plan
- Reset, then idle 5 cycles → `m_valid` 0, `s_ready` 1, `occ` 0, both counters 0.
- Stream 0x01..0x10 (16 vectors) with `m_ready` = 1 → outputs 0x01..0x10 in order, one per cycle, first one cycle after acceptance. End state: `xfer_cnt` 16, `stall_cnt` 0.
- With `m_ready` = 0, offer 0xA1, 0xA2, 0xA3 back-to-back:
  - 0xA1 and 0xA2 are accepted, `occ` 2, `s_ready` 0, 0xA3 is held upstream;
  - raise `m_ready` → outputs 0xA1, 0xA2, 0xA3 in order with no loss.
- Random `s_valid` and `m_ready` (50%) over 10k vectors against a scoreboard → exact in-order match. `stall_cnt` equals the cycles with `m_valid && !m_ready`.
- Assert `rst` for 1 cycle while `occ` = 2 → the next cycle shows `occ` 0, `m_valid` 0, counters 0, and neither buffered vector is ever emitted.
- Preload `stall_cnt` near max (CntWidth=4 build) and hold `m_ready` = 0 for 20 cycles → `stall_cnt` saturates at 0xF. Force 17 transfers → `xfer_cnt` wraps to 1.
